// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: round-robin arbitration of two pixel writers,
// (x, y) to linear address conversion, and a full-frame fill sequencer.
module fb_write_sched #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [9:0]    req_x0,
    input  logic [9:0]    req_x1,
    input  logic [9:0]    req_y0,
    input  logic [9:0]    req_y1,
    input  logic [DW-1:0] req_d0,
    input  logic [DW-1:0] req_d1,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          oob,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          we
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_FILL   = 1'b1;
    localparam logic [AW-1:0] H_RES_W   = AW'(H_RES);
    localparam logic [10:0]   H_LIM     = 11'(H_RES);
    localparam logic [10:0]   V_LIM     = 11'(V_RES);
    localparam logic [AW-1:0] FILL_LAST = AW'(H_RES * V_RES - 1);

    logic [0:0]    state_r;
    logic          last_r;
    logic [DW-1:0] color_r;
    logic [AW-1:0] w_addr_r;
    logic [DW-1:0] w_data_r;
    logic          we_r;
    logic          fill_busy_r;
    logic          fill_done_r;
    logic          oob_r;

    logic [1:0]    grant_s;
    logic          sel_s;
    logic          hs_s;
    logic [9:0]    x_s;
    logic [9:0]    y_s;
    logic [DW-1:0] d_s;
    logic [AW-1:0] addr_s;
    logic          inb_s;

    // Round-robin grant; gated by reset so req_ready reads 0 while rstn is low.
    always_comb begin
        grant_s = 2'b00;
        if (rstn && (state_r == ST_IDLE) && !fill_start) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    // Granted requester's coordinates, linear address and range check.
    always_comb begin
        sel_s  = grant_s[1];
        hs_s   = |grant_s;
        x_s    = sel_s ? req_x1 : req_x0;
        y_s    = sel_s ? req_y1 : req_y0;
        d_s    = sel_s ? req_d1 : req_d0;
        addr_s = AW'(y_s) * H_RES_W + AW'(x_s);
        inb_s  = ({1'b0, x_s} < H_LIM) && ({1'b0, y_s} < V_LIM);
    end

    // Scheduler state, pointer and registered write port; w_addr doubles as the fill counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            color_r     <= {DW{1'b0}};
            w_addr_r    <= {AW{1'b0}};
            w_data_r    <= {DW{1'b0}};
            we_r        <= 1'b0;
            fill_busy_r <= 1'b0;
            fill_done_r <= 1'b0;
            oob_r       <= 1'b0;
        end else begin
            we_r        <= 1'b0;
            fill_done_r <= 1'b0;
            oob_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fill_start) begin
                        state_r     <= ST_FILL;
                        color_r     <= fill_color;
                        fill_busy_r <= 1'b1;
                        we_r        <= 1'b1;
                        w_addr_r    <= {AW{1'b0}};
                        w_data_r    <= fill_color;
                    end else if (hs_s) begin
                        last_r <= sel_s;
                        if (inb_s) begin
                            we_r     <= 1'b1;
                            w_addr_r <= addr_s;
                            w_data_r <= d_s;
                        end else begin
                            oob_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (w_addr_r == FILL_LAST) begin
                        state_r     <= ST_IDLE;
                        fill_busy_r <= 1'b0;
                        fill_done_r <= 1'b1;
                    end else begin
                        we_r     <= 1'b1;
                        w_addr_r <= w_addr_r + AW'(1'b1);
                        w_data_r <= color_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = grant_s;
    assign w_addr    = w_addr_r;
    assign w_data    = w_data_r;
    assign we        = we_r;
    assign fill_busy = fill_busy_r;
    assign fill_done = fill_done_r;
    assign oob       = oob_r;

endmodule
